adsr_envelope_bank: RTL

//  - NUM_VOICES independent linear ADSR envelope generators; shared A/D/S/R settings, per-voice gate.
//  - Successor to the single-voice envelope generator; runs on the main clock, gated by a

---
 rtl/adsr_envelope_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/adsr_envelope_bank.sv
// Bank of NUM_VOICES linear ADSR envelope generators with shared rates and per-voice gates.
// Optional feature: define ADSR_LEGATO_EN so a retrigger from a sounding voice ramps up from its current level.
module adsr_envelope_bank #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned LEVEL_BITS = 8,
    parameter int unsigned RATE_BITS  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             sample_tick_i,
    input  logic [NUM_VOICES-1:0]            gate_i,
    input  logic [RATE_BITS-1:0]             attack_i,
    input  logic [RATE_BITS-1:0]             decay_i,
    input  logic [LEVEL_BITS-1:0]            sustain_i,
    input  logic [RATE_BITS-1:0]             rel_i,
    output logic [NUM_VOICES*LEVEL_BITS-1:0] level_o,
    output logic [NUM_VOICES*3-1:0]          state_o,
    output logic [NUM_VOICES-1:0]            active_o
);

    localparam int unsigned PS_W = (2 ** RATE_BITS) - 1;
    localparam logic [LEVEL_BITS-1:0] LVL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    env_state_e            state_q  [NUM_VOICES];
    env_state_e            state_d  [NUM_VOICES];
    logic [LEVEL_BITS-1:0] level_q  [NUM_VOICES];
    logic [LEVEL_BITS-1:0] level_d  [NUM_VOICES];
    logic [PS_W-1:0]       ps_q     [NUM_VOICES];
    logic [PS_W-1:0]       ps_d     [NUM_VOICES];
    logic [RATE_BITS-1:0]  rate_sel [NUM_VOICES];
    logic [PS_W-1:0]       lim      [NUM_VOICES];
    logic [PS_W-1:0]       ps_adv   [NUM_VOICES];
    logic [NUM_VOICES-1:0] step;
    logic [NUM_VOICES-1:0] rise;
    logic [NUM_VOICES-1:0] gate_prev_q;
    logic [NUM_VOICES-1:0] gate_prev_d;
    logic [NUM_VOICES-1:0] active_q;
    logic [NUM_VOICES-1:0] active_d;

    // Per-voice next-state: gate rise > gate low > normal progression, evaluated only on ticks.
    always_comb begin
        gate_prev_d = gate_prev_q;
        if (sample_tick_i) begin
            gate_prev_d = gate_i;
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            case (state_q[v])
                ST_ATTACK:  rate_sel[v] = attack_i;
                ST_DECAY:   rate_sel[v] = decay_i;
                ST_RELEASE: rate_sel[v] = rel_i;
                default:    rate_sel[v] = '0;
            endcase
            // Modular wrap makes the widest rate yield an all-ones limit.
            lim[v]    = (PS_W'(1) << rate_sel[v]) - PS_W'(1);
            step[v]   = (ps_q[v] == lim[v]);
            ps_adv[v] = (ps_q[v] >= lim[v]) ? '0 : ps_q[v] + PS_W'(1);
            rise[v]   = gate_i[v] & ~gate_prev_q[v];

            state_d[v] = state_q[v];
            level_d[v] = level_q[v];
            ps_d[v]    = ps_q[v];

            if (sample_tick_i) begin
                if (rise[v]) begin
                    state_d[v] = ST_ATTACK;
                    ps_d[v]    = '0;
`ifdef ADSR_LEGATO_EN
                    level_d[v] = (state_q[v] == ST_IDLE) ? '0 : level_q[v];
`else
                    level_d[v] = '0;
`endif
                end else if (!gate_i[v] && (state_q[v] == ST_ATTACK || state_q[v] == ST_DECAY ||
                                            state_q[v] == ST_SUSTAIN)) begin
                    state_d[v] = ST_RELEASE;
                    ps_d[v]    = '0;
                end else begin
                    case (state_q[v])
                        ST_ATTACK: begin
                            ps_d[v] = ps_adv[v];
                            if (step[v]) begin
                                if (level_q[v] >= LVL_MAX - LEVEL_BITS'(1)) begin
                                    level_d[v] = LVL_MAX;
                                    state_d[v] = ST_DECAY;
                                    ps_d[v]    = '0;
                                end else begin
                                    level_d[v] = level_q[v] + LEVEL_BITS'(1);
                                end
                            end
                        end
                        ST_DECAY: begin
                            // A step landing on the sustain level settles in the same tick.
                            if (level_q[v] <= sustain_i ||
                                (step[v] && (level_q[v] - LEVEL_BITS'(1)) <= sustain_i)) begin
                                level_d[v] = sustain_i;
                                state_d[v] = ST_SUSTAIN;
                                ps_d[v]    = '0;
                            end else begin
                                ps_d[v] = ps_adv[v];
                                if (step[v]) begin
                                    level_d[v] = level_q[v] - LEVEL_BITS'(1);
                                end
                            end
                        end
                        ST_SUSTAIN: begin
                            level_d[v] = sustain_i;
                            ps_d[v]    = '0;
                        end
                        ST_RELEASE: begin
                            if (level_q[v] == '0 || (step[v] && level_q[v] == LEVEL_BITS'(1))) begin
                                level_d[v] = '0;
                                state_d[v] = ST_IDLE;
                                ps_d[v]    = '0;
                            end else begin
                                ps_d[v] = ps_adv[v];
                                if (step[v]) begin
                                    level_d[v] = level_q[v] - LEVEL_BITS'(1);
                                end
                            end
                        end
                        default: begin
                            state_d[v] = ST_IDLE;
                            level_d[v] = '0;
                            ps_d[v]    = '0;
                        end
                    endcase
                end
            end
            active_d[v] = (state_d[v] != ST_IDLE);
        end
    end

    // Gate history loads the live gate during reset so a key held across reset is not a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                level_q[v] <= '0;
                ps_q[v]    <= '0;
            end
            gate_prev_q <= gate_i;
            active_q    <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                level_q[v] <= level_d[v];
                ps_q[v]    <= ps_d[v];
            end
            gate_prev_q <= gate_prev_d;
            active_q    <= active_d;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign level_o[v*LEVEL_BITS +: LEVEL_BITS] = level_q[v];
        assign state_o[v*3 +: 3]                   = state_q[v];
    end
    assign active_o = active_q;

endmodule
